// File: rtl/ir_pwm_seq.sv
// IR-LED burst/carrier sequencer: bias warm-up, carrier-modulated mark/space bursts with
// repeat, drain, and a max-on-time watchdog that trips a sticky fault.
module ir_pwm_seq #(
   parameter int WARMUP_CYC = 64,
   parameter int DRAIN_CYC  = 16,
   parameter int MAX_ON_CYC = 4096
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_wdata,
   input  logic       start,
   input  logic       stop,
   input  logic       fault_clr,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic       irled_en,
   output logic       ir_pwm,
   output logic [7:0] cbit_ir,
   output logic       cbit_ir_half_cur
);

   // Control handshake: cfg_we, start, stop and fault_clr are single-cycle strobes sampled on
   // every rising edge; there is no ready. busy=0 (and fault=0) means the next start is accepted.

   localparam int SEQ_MAX = (WARMUP_CYC > DRAIN_CYC) ? WARMUP_CYC : DRAIN_CYC;
   localparam int SW      = $clog2(SEQ_MAX + 1);
   localparam int WW      = $clog2(MAX_ON_CYC + 1);

   localparam logic [SW-1:0] WARMUP_LAST = SW'(WARMUP_CYC - 1);
   localparam logic [SW-1:0] DRAIN_LAST  = SW'(DRAIN_CYC - 1);
   localparam logic [SW-1:0] SEQ_ONE     = SW'(1);
   localparam logic [WW-1:0] WD_LAST     = WW'(MAX_ON_CYC - 1);
   localparam logic [WW-1:0] WD_ONE      = WW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WARMUP = 3'd1,
      S_MARK   = 3'd2,
      S_SPACE  = 3'd3,
      S_DRAIN  = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t state;

   logic [7:0] cfg_period;
   logic [7:0] cfg_duty;
   logic [7:0] cfg_mark;
   logic [7:0] cfg_space;
   logic [7:0] cfg_repeat;
   logic [7:0] cfg_current;
   logic       cfg_half;

   logic [7:0] sh_period;
   logic [7:0] sh_duty;
   logic [7:0] sh_mark;
   logic [7:0] sh_space;
   logic [7:0] sh_repeat;

   logic [SW-1:0] seq_cnt;
   logic [7:0]    ph;
   logic [7:0]    per;
   logic [7:0]    rep;
   logic [WW-1:0] wd;

   logic [7:0] p_eff;
   logic [7:0] p_last;
   logic [7:0] d_eff;
   logic [7:0] mark_last;
   logic [7:0] space_last;
   logic       period_end;
   logic       last_rep;
   logic       next_high;
   logic       first_high;
   logic       wd_trip;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_period  <= 8'd0;
         cfg_duty    <= 8'd0;
         cfg_mark    <= 8'd0;
         cfg_space   <= 8'd0;
         cfg_repeat  <= 8'd0;
         cfg_current <= 8'd0;
         cfg_half    <= 1'b0;
      end else if (cfg_we) begin
         case (cfg_addr)
            3'd0:    cfg_period  <= cfg_wdata;
            3'd1:    cfg_duty    <= cfg_wdata;
            3'd2:    cfg_mark    <= cfg_wdata;
            3'd3:    cfg_space   <= cfg_wdata;
            3'd4:    cfg_repeat  <= cfg_wdata;
            3'd5:    cfg_current <= cfg_wdata;
            3'd6:    cfg_half    <= cfg_wdata[0];
            default: ;
         endcase
      end
   end

   // Carrier period is at least 2 so a full-duty carrier still has a defined period boundary.
   assign p_eff      = (sh_period < 8'd2) ? 8'd2 : sh_period;
   assign p_last     = p_eff - 8'd1;
   assign d_eff      = (sh_duty > p_eff) ? p_eff : sh_duty;
   assign mark_last  = (sh_mark == 8'd0) ? 8'd0 : (sh_mark - 8'd1);
   assign space_last = sh_space - 8'd1;
   assign period_end = (ph == p_last);
   assign last_rep   = (sh_repeat != 8'd0) && (rep == (sh_repeat - 8'd1));
   assign next_high  = (({1'b0, ph} + 9'd1) < {1'b0, d_eff});
   assign first_high = (d_eff != 8'd0);
   assign wd_trip    = ir_pwm && (wd == WD_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= S_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         fault            <= 1'b0;
         irled_en         <= 1'b0;
         ir_pwm           <= 1'b0;
         cbit_ir          <= 8'd0;
         cbit_ir_half_cur <= 1'b0;
         sh_period        <= 8'd0;
         sh_duty          <= 8'd0;
         sh_mark          <= 8'd0;
         sh_space         <= 8'd0;
         sh_repeat        <= 8'd0;
         seq_cnt          <= '0;
         ph               <= 8'd0;
         per              <= 8'd0;
         rep              <= 8'd0;
         wd               <= '0;
      end else begin
         done <= 1'b0;
         // wd counts the high cycles already seen; the trip stops it before it can wrap
         wd   <= ir_pwm ? (wd + WD_ONE) : '0;

         if (wd_trip) begin
            state    <= S_FAULT;
            busy     <= 1'b0;
            fault    <= 1'b1;
            irled_en <= 1'b0;
            ir_pwm   <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !stop) begin
                     state            <= S_WARMUP;
                     busy             <= 1'b1;
                     irled_en         <= 1'b1;
                     ir_pwm           <= 1'b0;
                     sh_period        <= cfg_period;
                     sh_duty          <= cfg_duty;
                     sh_mark          <= cfg_mark;
                     sh_space         <= cfg_space;
                     sh_repeat        <= cfg_repeat;
                     cbit_ir          <= cfg_current;
                     cbit_ir_half_cur <= cfg_half;
                     seq_cnt          <= '0;
                     rep              <= 8'd0;
                  end
               end

               S_WARMUP: begin
                  if (stop) begin
                     state   <= S_DRAIN;
                     ir_pwm  <= 1'b0;
                     seq_cnt <= '0;
                  end else if (seq_cnt == WARMUP_LAST) begin
                     state  <= S_MARK;
                     ph     <= 8'd0;
                     per    <= 8'd0;
                     ir_pwm <= first_high;
                  end else begin
                     seq_cnt <= seq_cnt + SEQ_ONE;
                  end
               end

               S_MARK: begin
                  if (stop) begin
                     state   <= S_DRAIN;
                     ir_pwm  <= 1'b0;
                     seq_cnt <= '0;
                  end else if (!period_end) begin
                     ph     <= ph + 8'd1;
                     ir_pwm <= next_high;
                  end else if (per != mark_last) begin
                     per    <= per + 8'd1;
                     ph     <= 8'd0;
                     ir_pwm <= first_high;
                  end else if (sh_space != 8'd0) begin
                     state  <= S_SPACE;
                     ph     <= 8'd0;
                     per    <= 8'd0;
                     ir_pwm <= 1'b0;
                  end else if (last_rep) begin
                     state   <= S_DRAIN;
                     ir_pwm  <= 1'b0;
                     seq_cnt <= '0;
                  end else begin
                     // back-to-back marks: a full-duty carrier stays high across the boundary
                     if (sh_repeat != 8'd0) rep <= rep + 8'd1;
                     ph     <= 8'd0;
                     per    <= 8'd0;
                     ir_pwm <= first_high;
                  end
               end

               S_SPACE: begin
                  if (stop) begin
                     state   <= S_DRAIN;
                     ir_pwm  <= 1'b0;
                     seq_cnt <= '0;
                  end else if (!period_end) begin
                     ph <= ph + 8'd1;
                  end else if (per != space_last) begin
                     per <= per + 8'd1;
                     ph  <= 8'd0;
                  end else if (last_rep) begin
                     state   <= S_DRAIN;
                     seq_cnt <= '0;
                  end else begin
                     if (sh_repeat != 8'd0) rep <= rep + 8'd1;
                     state  <= S_MARK;
                     ph     <= 8'd0;
                     per    <= 8'd0;
                     ir_pwm <= first_high;
                  end
               end

               S_DRAIN: begin
                  if (seq_cnt == DRAIN_LAST) begin
                     state    <= S_IDLE;
                     busy     <= 1'b0;
                     irled_en <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     seq_cnt <= seq_cnt + SEQ_ONE;
                  end
               end

               S_FAULT: begin
                  if (fault_clr) begin
                     state <= S_IDLE;
                     fault <= 1'b0;
                  end
               end

               default: begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  irled_en <= 1'b0;
                  ir_pwm   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
